coram_instream_filler: RTL and testbench
========================================

Name: coram_instream_filler

Overview:
- DMA-side producer for a CoRAM input stream (DRAM -> BRAM); the transmitter whose receiver is the user-logic stream consumer (Q/DEQ/EMPTY side).
- Takes a transfer command (base address, word count), splits it into memory read bursts, and enqueues returned words into the stream FIFO.
- Uses credit-based flow control so the stream FIFO never overflows.

Parameters:
ADDR_WIDTH, 32, byte address width of memory requests
DATA_WIDTH, 32, stream/memory word width (multiple of 8)
SIZE_WIDTH, 16, width of command word count
MAX_BURST, 16, maximum words per memory read burst (power of 2, <= FIFO_DEPTH)
FIFO_ADDR_LEN, 4, log2 of downstream stream FIFO depth; FIFO_DEPTH = 2**FIFO_ADDR_LEN

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, can accept command
cmd_addr  in  ADDR_WIDTH  byte base address
cmd_size  in  SIZE_WIDTH  transfer length in words
mem_req_valid  out  1  burst read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  burst byte address
mem_req_len  out  clog2(MAX_BURST)+1  burst length in words (1..MAX_BURST)
mem_rdata_valid  in  1  read data beat (no backpressure)
mem_rdata  in  DATA_WIDTH  read data
mem_rdata_last  in  1  final beat of burst
stream_d  out  DATA_WIDTH  word to stream FIFO
stream_enq  out  1  enqueue strobe
stream_deq  in  1  consumer dequeue (credit return)
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion
err  out  1  sticky protocol error

Behaviour:
- Reset (async, RST=1): state IDLE; cmd_ready=1; mem_req_valid=0, mem_req_addr=0, mem_req_len=0; stream_enq=0, stream_d=0; busy=0, done=0, err=0; credits=FIFO_DEPTH; counters 0. Reset mid-transfer abandons it; late data beats after reset release are ignored in IDLE.
- FSM states: IDLE, REQ, DATA, FIN.
- IDLE: cmd_ready=1. Handshake cmd_valid&cmd_ready at cycle T latches addr/size into cur_addr/remaining; busy=1 from T+1. size!=0 -> REQ; size==0 -> FIN.
- REQ: len = min(remaining, MAX_BURST). mem_req_valid asserted only when credits >= len; addr/len held stable while valid & !ready. Earliest mem_req_valid is T+1. On mem_req_valid&mem_req_ready: credits -= len, remaining -= len, cur_addr += len*(DATA_WIDTH/8) (wraps modulo 2**ADDR_WIDTH), beat counter = 0 -> DATA.
- One outstanding burst at a time.
- DATA: each mem_rdata_valid -> registered stream_enq=1, stream_d=mem_rdata next cycle (latency 1); beat counter++. Burst ends on beat count == len (counter is authoritative). mem_rdata_last on a beat other than the final one, or absent on the final one -> err=1 (sticky until reset). At end: remaining>0 -> REQ, else FIN.
- FIN: done=1 for exactly one cycle, busy=0 -> IDLE. Earliest new command accepted one cycle later.
- Credits: range 0..FIFO_DEPTH; each cycle credits = credits - (reserve ? len : 0) + (stream_deq ? 1 : 0), with simultaneous reserve and deq both applied. stream_deq when credits==FIFO_DEPTH and no reserve -> ignored, err=1.
- mem_rdata_valid outside DATA -> ignored, err=1.

Decomposition:
- Package coram_dma_pkg: FSM state enum (IDLE/REQ/DATA/FIN), burst-length width constant, min() burst-length function.
- Sub-module coram_credit_counter (FIFO_ADDR_LEN parameter; reserve/len/release inputs; credits and overflow-error outputs).

Test Plan:
- Basic transfer: cmd addr 0x1000, size 40; consumer deqs every cycle -> requests (0x1000,16), (0x1040,16), (0x1080,8); 40 enqs in order; one done pulse; err=0.
- Zero-size command: size 0 -> no mem_req_valid; done pulses 2 cycles after handshake; cmd_ready=1 the cycle after done.
- Backpressure: size 32, no deq -> first burst (16) issued, second withheld with credits=0; after 16 deq pulses, mem_req_valid asserted the next cycle.
- Request stall: mem_req_ready=0 for 5 cycles -> addr/len stable throughout; single acceptance; credits drop by exactly 16.
- Reset mid-DATA: assert RST after beat 5 of 16 -> all outputs immediately 0, cmd_ready=1, credits=16; subsequent stray beats do not produce stream_enq.
- Protocol error: mem_rdata_last on beat 3 of an 8-beat burst -> err=1 and stays 1; transfer still ends after 8 beats and done pulses.

Source files
------------

// File: rtl/coram_dma_pkg.sv
// Shared types and helpers for the CoRAM input-stream DMA filler.
package coram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int MAX_BURST_DEF = 16;

  // Width of a burst-length field able to hold 1..max_burst inclusive.
  function automatic int blen_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  // Next burst size: whatever is left, capped at the burst limit.
  function automatic logic [31:0] min_burst(input logic [31:0] rem, input logic [31:0] max_b);
    return (rem < max_b) ? rem : max_b;
  endfunction

endpackage

// File: rtl/coram_credit_counter.sv
// Tracks free slots in the downstream stream FIFO. Bursts reserve their full
// length up front; each consumer dequeue hands one slot back.
module coram_credit_counter #(
  parameter int FIFO_ADDR_LEN = 4,
  parameter int LEN_W         = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reserve_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   release_i,
  output logic [FIFO_ADDR_LEN:0] credits_o,
  output logic                   ovf_o
);

  localparam int            CW    = FIFO_ADDR_LEN + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** FIFO_ADDR_LEN);

  logic [CW-1:0] credits_q, credits_d;

  // A dequeue while already full (and nothing being reserved) cannot be real.
  assign ovf_o     = release_i && !reserve_i && (credits_q == DEPTH);
  assign credits_o = credits_q;

  // Reserve and release in the same cycle both take effect.
  always_comb begin
    credits_d = credits_q;
    if (reserve_i) credits_d = credits_d - CW'(len_i);
    if (release_i && !ovf_o) credits_d = credits_d + CW'(1);
  end

  // Credit register; a fresh reset means an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credits_q <= DEPTH;
    else     credits_q <= credits_d;
  end

endmodule

// File: rtl/coram_instream_filler.sv
// DRAM -> stream FIFO filler: splits a command into bursts, issues them one at
// a time once enough FIFO credit exists, and forwards returned beats.
module coram_instream_filler
  import coram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 16,
  parameter int MAX_BURST     = MAX_BURST_DEF,
  parameter int FIFO_ADDR_LEN = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [SIZE_WIDTH-1:0]        cmd_size,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  output logic [blen_w(MAX_BURST)-1:0] mem_req_len,
  input  logic                         mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         mem_rdata_last,
  output logic [DATA_WIDTH-1:0]        stream_d,
  output logic                         stream_enq,
  input  logic                         stream_deq,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int LW  = blen_w(MAX_BURST);
  localparam int CW  = FIFO_ADDR_LEN + 1;
  localparam int BPW = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  enq_q, enq_d;
  logic [DATA_WIDTH-1:0] sd_q, sd_d;

  logic [LW-1:0] burst_len;
  logic [CW-1:0] credits;
  logic          credit_ovf;
  logic          can_issue;
  logic          req_fire;
  logic          last_beat;

  assign burst_len = LW'(min_burst(32'(remaining_q), 32'(MAX_BURST)));
  assign can_issue = (state_q == REQ) && (credits >= CW'(burst_len));
  assign req_fire  = can_issue && mem_req_ready;
  assign last_beat = (cnt_q + LW'(1)) == len_q;

  // Request fields track live state, which does not move while stalled.
  assign mem_req_valid = can_issue;
  assign mem_req_addr  = (state_q == REQ) ? cur_addr_q : '0;
  assign mem_req_len   = (state_q == REQ) ? burst_len  : '0;

  // The done cycle still blocks commands so a new one starts a cycle later.
  assign cmd_ready  = (state_q == IDLE) && !done_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign stream_enq = enq_q;
  assign stream_d   = sd_q;

  coram_credit_counter #(
    .FIFO_ADDR_LEN(FIFO_ADDR_LEN),
    .LEN_W        (LW)
  ) u_credit (
    .clk      (CLK),
    .rst      (RST),
    .reserve_i(req_fire),
    .len_i    (burst_len),
    .release_i(stream_deq),
    .credits_o(credits),
    .ovf_o    (credit_ovf)
  );

  // Next-state logic: command latch, burst issue, beat forwarding, completion.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    enq_d       = 1'b0;
    sd_d        = sd_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_size;
          busy_d      = 1'b1;
          state_d     = (cmd_size == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        if (req_fire) begin
          remaining_d = remaining_q - SIZE_WIDTH'(burst_len);
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BPW);
          len_d       = burst_len;
          cnt_d       = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (mem_rdata_valid) begin
          enq_d = 1'b1;
          sd_d  = mem_rdata;
          cnt_d = cnt_q + LW'(1);
          // Beat count decides burst end; a mismatched last flag is only flagged.
          if (mem_rdata_last != last_beat) err_d = 1'b1;
          if (last_beat) state_d = (remaining_q == '0) ? FIN : REQ;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (mem_rdata_valid && state_q != DATA) err_d = 1'b1;
    if (credit_ovf) err_d = 1'b1;
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      enq_q       <= 1'b0;
      sd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      enq_q       <= enq_d;
      sd_q        <= sd_d;
    end
  end

endmodule

// File: tb/tb_coram_instream_filler.sv
// Scoreboard bench: commands push expected bursts, the memory responder pushes
// expected stream words, and a negedge monitor pops and compares.
module tb_coram_instream_filler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_size = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [4:0]  mem_req_len;
  logic        mem_rdata_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdata_last = 1'b0;
  logic [31:0] stream_d;
  logic        stream_enq;
  logic        stream_deq = 1'b0;
  logic        busy, done, err;

  coram_instream_filler dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .mem_rdata_last(mem_rdata_last),
    .stream_d(stream_d), .stream_enq(stream_enq), .stream_deq(stream_deq),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_data[$];
  int          burst_q[$];

  int checks = 0, errors = 0;
  int enq_cnt = 0, deq_cnt = 0, flushed = 0, done_cnt = 0, acc_cnt = 0;
  int ready_mode = 1, deq_mode = 1, man_deq = 0, gap_en = 0;
  int beat_lim = -1, stray_n = 0, bad_beat = 0, rsp_beat = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted request and enqueued word against the queues.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [4:0]  prev_len = '0;
  always @(negedge CLK) begin
    req_t        r;
    logic [31:0] w;
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("req_valid_held", longint'(mem_req_valid), 1);
        chk("req_addr_stable", longint'(mem_req_addr), longint'(prev_addr));
        chk("req_len_stable", longint'(mem_req_len), longint'(prev_len));
      end
      if (mem_req_valid && mem_req_ready) begin
        acc_cnt++;
        if (exp_req.size() == 0) begin
          chk("unexpected_req", longint'(mem_req_addr), -1);
        end else begin
          r = exp_req.pop_front();
          chk("req_addr", longint'(mem_req_addr), longint'(r.addr));
          chk("req_len", longint'(mem_req_len), longint'(r.len));
          burst_q.push_back(r.len);
        end
      end
      if (stream_enq) begin
        enq_cnt++;
        if (exp_data.size() == 0) begin
          chk("unexpected_enq", longint'(stream_d), -1);
        end else begin
          w = exp_data.pop_front();
          chk("stream_d", longint'(stream_d), longint'(w));
        end
      end
      if (done) done_cnt++;
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      prev_len   = mem_req_len;
    end
  end

  // Memory request acceptance pattern.
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       mem_req_ready = 1'($urandom % 2);
      1:       mem_req_ready = 1'b1;
      default: mem_req_ready = 1'b0;
    endcase
  end

  // Consumer: only dequeues words the FIFO actually holds.
  always @(posedge CLK) begin
    #1;
    stream_deq = 1'b0;
    if (enq_cnt - deq_cnt - flushed > 0) begin
      case (deq_mode)
        1: stream_deq = 1'b1;
        2: stream_deq = 1'($urandom % 2);
        3: if (man_deq > 0) begin stream_deq = 1'b1; man_deq--; end
        default: stream_deq = 1'b0;
      endcase
    end
    if (stream_deq) deq_cnt++;
  end

  // Memory responder: serves accepted bursts beat by beat, random data.
  always @(posedge CLK) begin
    #1;
    mem_rdata_valid = 1'b0;
    mem_rdata_last  = 1'b0;
    if (stray_n > 0) begin
      mem_rdata_valid = 1'b1;
      mem_rdata_last  = 1'b1;
      mem_rdata       = $urandom;
      stray_n--;
    end else if (!RST && burst_q.size() > 0 && beat_lim != 0 &&
                 !(gap_en != 0 && $urandom % 3 == 0)) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = $urandom;
      rsp_beat++;
      mem_rdata_last  = (rsp_beat == burst_q[0]) || (rsp_beat == bad_beat);
      exp_data.push_back(mem_rdata);
      if (beat_lim > 0) beat_lim--;
      if (rsp_beat == burst_q[0]) begin
        void'(burst_q.pop_front());
        rsp_beat = 0;
      end
    end
  end

  // Reference model: split into capped bursts, 4-byte words, 32-bit wrap.
  task automatic issue(input logic [31:0] a, input int s);
    logic [31:0] ad;
    int rem, l, k;
    ad = a;
    rem = s;
    while (rem > 0) begin
      l = (rem > 16) ? 16 : rem;
      exp_req.push_back('{addr: ad, len: l});
      ad  = ad + 32'(l * 4);
      rem = rem - l;
    end
    @(posedge CLK); #1;
    cmd_addr  = a;
    cmd_size  = 16'(s);
    cmd_valid = 1'b1;
    k = 0;
    @(negedge CLK);
    while (!cmd_ready && k < 50) begin @(negedge CLK); k++; end
    chk("cmd_accept", longint'(cmd_ready), 1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin @(negedge CLK); #1; k++; end
    repeat (3) begin @(negedge CLK); #1; end
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic post_chk(input int exp_err);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("data_queue_empty", exp_data.size(), 0);
    chk("bursts_served", burst_q.size(), 0);
    chk("err", longint'(err), exp_err);
  endtask

  initial begin
    int e0, a0, k;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_req_valid", longint'(mem_req_valid), 0);
    chk("rst_req_addr", longint'(mem_req_addr), 0);
    chk("rst_req_len", longint'(mem_req_len), 0);
    chk("rst_enq", longint'(stream_enq), 0);
    chk("rst_stream_d", longint'(stream_d), 0);
    chk("rst_credits", longint'(dut.u_credit.credits_o), 16);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Basic 40-word transfer, consumer drains every cycle.
    e0 = enq_cnt; a0 = acc_cnt;
    issue(32'h1000, 40);
    wait_done(500);
    chk("basic_enqs", enq_cnt - e0, 40);
    chk("basic_reqs", acc_cnt - a0, 3);
    post_chk(0);

    // Randomized transfers with random ready, deq and beat gaps, plus an address wrap.
    ready_mode = 0; deq_mode = 2; gap_en = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) issue(32'hFFFF_FFF0, 20);
      else        issue($urandom, $urandom_range(1, 50));
      wait_done(3000);
      post_chk(0);
    end
    ready_mode = 1; deq_mode = 1; gap_en = 0;
    repeat (20) @(negedge CLK);
    chk("credits_idle", longint'(dut.u_credit.credits_o), 16);

    // Zero-size command: no request, done two cycles after the handshake.
    a0 = acc_cnt;
    issue(32'h2000, 0);
    @(negedge CLK);
    chk("zs_busy", longint'(busy), 1);
    chk("zs_done_early", longint'(done), 0);
    chk("zs_cmd_ready_busy", longint'(cmd_ready), 0);
    @(negedge CLK);
    chk("zs_done", longint'(done), 1);
    chk("zs_busy_clear", longint'(busy), 0);
    chk("zs_cmd_ready_done", longint'(cmd_ready), 0);
    @(negedge CLK);
    chk("zs_cmd_ready_after", longint'(cmd_ready), 1);
    chk("zs_done_once", longint'(done), 0);
    chk("zs_no_req", acc_cnt - a0, 0);

    // Backpressure: 32 words, no consumer until the first burst fills the FIFO.
    deq_mode = 0; e0 = enq_cnt; a0 = acc_cnt;
    issue(32'h3000, 32);
    k = 0;
    while (enq_cnt - e0 < 16 && k < 200) begin @(negedge CLK); #1; k++; end
    repeat (3) @(negedge CLK);
    chk("bp_withheld", longint'(mem_req_valid), 0);
    chk("bp_credits", longint'(dut.u_credit.credits_o), 0);
    chk("bp_one_burst", acc_cnt - a0, 1);
    man_deq = 16; deq_mode = 3;
    k = 0;
    while (man_deq > 0 && k < 100) begin @(negedge CLK); #1; k++; end
    chk("bp_still_withheld", longint'(mem_req_valid), 0);
    @(negedge CLK);
    chk("bp_released", longint'(mem_req_valid), 1);
    deq_mode = 1;
    wait_done(500);
    chk("bp_enqs", enq_cnt - e0, 32);
    post_chk(0);

    // Request stall: ready held low while valid.
    ready_mode = 2; a0 = acc_cnt;
    issue(32'h4000, 16);
    k = 0;
    while (!mem_req_valid && k < 20) begin @(negedge CLK); k++; end
    chk("stall_credits_before", longint'(dut.u_credit.credits_o), 16);
    repeat (5) begin
      @(negedge CLK);
      chk("stall_addr", longint'(mem_req_addr), 32'h4000);
      chk("stall_len", longint'(mem_req_len), 16);
    end
    ready_mode = 1;
    k = 0;
    while (acc_cnt == a0 && k < 10) begin @(negedge CLK); #1; k++; end
    @(negedge CLK);
    chk("stall_credits_after", longint'(dut.u_credit.credits_o), 0);
    wait_done(500);
    chk("stall_single_accept", acc_cnt - a0, 1);
    post_chk(0);

    // Reset in the middle of a burst, then stray beats.
    beat_lim = 5; e0 = enq_cnt;
    issue(32'h5000, 16);
    k = 0;
    while (enq_cnt - e0 < 5 && k < 100) begin @(negedge CLK); #1; k++; end
    chk("mid_enqs", enq_cnt - e0, 5);
    deq_mode = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("mr_enq", longint'(stream_enq), 0);
    chk("mr_req_valid", longint'(mem_req_valid), 0);
    chk("mr_busy", longint'(busy), 0);
    chk("mr_done", longint'(done), 0);
    chk("mr_err", longint'(err), 0);
    chk("mr_cmd_ready", longint'(cmd_ready), 1);
    chk("mr_credits", longint'(dut.u_credit.credits_o), 16);
    exp_req.delete(); exp_data.delete(); burst_q.delete();
    rsp_beat = 0; beat_lim = -1;
    flushed = enq_cnt - deq_cnt;
    @(posedge CLK); #1;
    RST = 1'b0;
    e0 = enq_cnt;
    stray_n = 3;
    repeat (6) @(negedge CLK);
    #1;
    chk("stray_no_enq", enq_cnt - e0, 0);
    chk("stray_err", longint'(err), 1);
    chk("stray_idle", longint'(busy), 0);
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("err_cleared", longint'(err), 0);

    // Early last flag on beat 3 of an 8-beat burst.
    deq_mode = 1; bad_beat = 3; e0 = enq_cnt;
    issue(32'h6000, 8);
    wait_done(500);
    chk("pe_enqs", enq_cnt - e0, 8);
    post_chk(1);
    repeat (5) @(negedge CLK);
    chk("pe_err_sticky", longint'(err), 1);
    bad_beat = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
